// File: rtl/idu_fwd_decode_stage.sv
// RV32I/E decode stage: decodes one instruction, resolves operands through a
// priority-ordered forwarding network and holds the result in a valid/ready slot.
module idu_fwd_decode_stage #(
  parameter int REG_IDX_W  = 4,
  parameter int FWD_STAGES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [31:0]                     inst,
  input  logic [31:0]                     pc,
  output logic [REG_IDX_W-1:0]            rs1_idx,
  output logic [REG_IDX_W-1:0]            rs2_idx,
  input  logic [31:0]                     rs1_data,
  input  logic [31:0]                     rs2_data,
  input  logic [FWD_STAGES*REG_IDX_W-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]           fwd_wen,
  input  logic [FWD_STAGES-1:0]           fwd_dvalid,
  input  logic [FWD_STAGES*32-1:0]        fwd_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_pc,
  output logic [31:0]                     out_src1,
  output logic [31:0]                     out_src2,
  output logic [31:0]                     out_store_data,
  output logic [31:0]                     out_imm,
  output logic [REG_IDX_W-1:0]            out_rd,
  output logic [3:0]                      out_alu_op,
  output logic                            out_reg_wen,
  output logic [2:0]                      out_mem_rd,
  output logic [1:0]                      out_mem_wr,
  output logic                            out_jump,
  output logic                            out_illegal,
  output logic [CNT_W-1:0]                stall_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Register ALU ops are {inst[30],funct3}; branch compares use the six unused codes.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_EQ  = 4'b1001;
  localparam logic [3:0] ALU_NEQ = 4'b1010;
  localparam logic [3:0] ALU_LT  = 4'b1011;
  localparam logic [3:0] ALU_GE  = 4'b1100;
  localparam logic [3:0] ALU_LTU = 4'b1110;
  localparam logic [3:0] ALU_GEU = 4'b1111;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          src1;
    logic [31:0]          src2;
    logic [31:0]          store_data;
    logic [31:0]          imm;
    logic [REG_IDX_W-1:0] rd;
    logic [3:0]           alu_op;
    logic                 reg_wen;
    logic [2:0]           mem_rd;
    logic [1:0]           mem_wr;
    logic                 jump;
    logic                 illegal;
  } bundle_t;

  // Returns {hazard, value}; the youngest (lowest-index) matching writer wins.
  function automatic logic [32:0] fwd_resolve(
    input logic [REG_IDX_W-1:0]            idx,
    input logic [31:0]                     rdata,
    input logic [FWD_STAGES*REG_IDX_W-1:0] rd_v,
    input logic [FWD_STAGES-1:0]           wen_v,
    input logic [FWD_STAGES-1:0]           dv_v,
    input logic [FWD_STAGES*32-1:0]        data_v
  );
    logic [32:0] r;
    r = {1'b0, rdata};
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (wen_v[i] && (rd_v[i*REG_IDX_W +: REG_IDX_W] == idx))
        r = dv_v[i] ? {1'b0, data_v[i*32 +: 32]} : {1'b1, rdata};
    end
    if (idx == '0) r = '0;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [32:0]        rs1_res, rs2_res;
  logic [31:0]        rs1_val, rs2_val;
  logic               use_rs1, use_rs2, hazard, fire;
  bundle_t            dec;

  logic               vld_p1;
  bundle_t            bundle_p1;
  logic [CNT_W-1:0]   stall_cnt_p1;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign rs1_idx = inst[15 +: REG_IDX_W];
  assign rs2_idx = inst[20 +: REG_IDX_W];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_res = fwd_resolve(rs1_idx, rs1_data, fwd_rd, fwd_wen, fwd_dvalid, fwd_data);
  assign rs2_res = fwd_resolve(rs2_idx, rs2_data, fwd_rd, fwd_wen, fwd_dvalid, fwd_data);
  assign rs1_val = rs1_res[31:0];
  assign rs2_val = rs2_res[31:0];

  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.rd      = inst[7 +: REG_IDX_W];
    dec.alu_op  = ALU_ADD;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.src1 = rs1_val; dec.src2 = rs2_val;
        dec.alu_op = {inst[30], funct3}; dec.reg_wen = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i; dec.src1 = rs1_val; dec.src2 = imm_i;
        dec.alu_op = {(funct3 == 3'b101) & inst[30], funct3}; dec.reg_wen = 1'b1;
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i; dec.src1 = rs1_val; dec.src2 = imm_i; dec.reg_wen = 1'b1;
        case (funct3)
          3'b000:  dec.mem_rd = 3'd1;
          3'b001:  dec.mem_rd = 3'd2;
          3'b010:  dec.mem_rd = 3'd3;
          3'b100:  dec.mem_rd = 3'd4;
          3'b101:  dec.mem_rd = 3'd5;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = imm_s; dec.src1 = rs1_val; dec.src2 = imm_s; dec.store_data = rs2_val;
        case (funct3)
          3'b000:  dec.mem_wr = 2'd1;
          3'b001:  dec.mem_wr = 2'd2;
          3'b010:  dec.mem_wr = 2'd3;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = imm_b; dec.src1 = rs1_val; dec.src2 = rs2_val;
        case (funct3)
          3'b001:  dec.alu_op = ALU_NEQ;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: dec.alu_op = ALU_EQ;
        endcase
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.src1 = pc; dec.src2 = imm_j;
        dec.reg_wen = 1'b1; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        dec.imm = imm_i; dec.src1 = rs1_val; dec.src2 = imm_i;
        dec.reg_wen = 1'b1; dec.jump = 1'b1;
      end
      OPC_LUI: begin
        dec.imm = imm_u; dec.src2 = imm_u; dec.reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.src1 = pc; dec.src2 = imm_u; dec.reg_wen = 1'b1;
      end
      OPC_SYSTEM: begin
        // Only CSRRW/CSRRS are recognised in the SYSTEM space.
        if (funct3 == 3'b001 || funct3 == 3'b010) begin
          use_rs1 = 1'b1;
          dec.imm = imm_i; dec.src1 = rs1_val; dec.src2 = imm_i; dec.reg_wen = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.reg_wen = 1'b0;
      dec.mem_rd  = 3'd0;
      dec.mem_wr  = 2'd0;
      dec.alu_op  = ALU_ADD;
      dec.jump    = 1'b0;
    end
  end

  assign hazard   = (use_rs1 && rs1_res[32]) || (use_rs2 && rs2_res[32]);
  assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  // ---- stage p0 -> p1: output slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      bundle_p1    <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (fire)      vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;
      if (fire) bundle_p1 <= dec;
      if (in_valid && hazard && !flush) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign out_valid      = vld_p1;
  assign out_pc         = bundle_p1.pc;
  assign out_src1       = bundle_p1.src1;
  assign out_src2       = bundle_p1.src2;
  assign out_store_data = bundle_p1.store_data;
  assign out_imm        = bundle_p1.imm;
  assign out_rd         = bundle_p1.rd;
  assign out_alu_op     = bundle_p1.alu_op;
  assign out_reg_wen    = bundle_p1.reg_wen;
  assign out_mem_rd     = bundle_p1.mem_rd;
  assign out_mem_wr     = bundle_p1.mem_wr;
  assign out_jump       = bundle_p1.jump;
  assign out_illegal    = bundle_p1.illegal;
  assign stall_cnt      = stall_cnt_p1;

endmodule
